md_ctrl: RTL

- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline; lives in the E stage beside the ALU.
- Owns the HI/LO registers, runs mult/multu/div/divu over a fixed latency and handles mthi/mtlo writes.
- Drives busy and a decode-stage stall so that a later md-class instruction in D waits until the unit is free.

---
 rtl/md_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs mult/multu/div/divu
// over a fixed busy period and handles mthi/mtlo writes.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md,
    output logic        err_start
);

    typedef enum logic {
        IDLE,
        RUN
    } mdState;

    mdState      state, stateNext;
    logic [3:0]  counter, counterNext;
    logic [31:0] hiReg, hiNext, loReg, loNext;
    logic [31:0] pendHi, pendHiNext, pendLo, pendLoNext;
    logic        errReg, errNext;

    logic        isArith;
    logic [63:0] prodSigned, prodUnsigned, result;
    logic [31:0] magA, magB, divisorS, divisorU;
    logic [31:0] quotMag, remMag, quotS, remS, quotU, remU;

    assign isArith = (md_op >= 3'd1) && (md_op <= 3'd4);

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps naturally to
    // 0x80000000 with remainder 0; a zero divisor is swapped for 1 and the result discarded.
    always_comb begin
        prodSigned   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prodUnsigned = {32'd0, rs_val} * {32'd0, rt_val};
        magA         = rs_val[31] ? (32'd0 - rs_val) : rs_val;
        magB         = rt_val[31] ? (32'd0 - rt_val) : rt_val;
        divisorS     = (magB == 32'd0) ? 32'd1 : magB;
        divisorU     = (rt_val == 32'd0) ? 32'd1 : rt_val;
        quotMag      = magA / divisorS;
        remMag       = magA % divisorS;
        quotS        = (rs_val[31] ^ rt_val[31]) ? (32'd0 - quotMag) : quotMag;
        remS         = rs_val[31] ? (32'd0 - remMag) : remMag;
        quotU        = rs_val / divisorU;
        remU         = rs_val % divisorU;
        case (md_op)
            3'd1:    result = prodSigned;
            3'd2:    result = prodUnsigned;
            3'd3:    result = (rt_val == 32'd0) ? {hiReg, loReg} : {remS, quotS};
            3'd4:    result = (rt_val == 32'd0) ? {hiReg, loReg} : {remU, quotU};
            default: result = {hiReg, loReg};
        endcase
    end

    // Next-state logic: accept work only while idle; commit the pending result on the last busy cycle.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        hiNext      = hiReg;
        loNext      = loReg;
        pendHiNext  = pendHi;
        pendLoNext  = pendLo;
        errNext     = start & (state == RUN);
        case (state)
            IDLE: begin
                if (start) begin
                    if (isArith) begin
                        stateNext   = RUN;
                        counterNext = (md_op <= 3'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        pendHiNext  = result[63:32];
                        pendLoNext  = result[31:0];
                    end else if (md_op == 3'd5) begin
                        hiNext = rs_val;
                    end else if (md_op == 3'd6) begin
                        loNext = rs_val;
                    end
                end
            end
            RUN: begin
                if (counter > 4'd1) begin
                    counterNext = counter - 4'd1;
                end else begin
                    counterNext = 4'd0;
                    stateNext   = IDLE;
                    hiNext      = pendHi;
                    loNext      = pendLo;
                end
            end
            default: begin
                stateNext   = IDLE;
                counterNext = 4'd0;
            end
        endcase
    end

    // State register; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 4'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            pendHi  <= 32'd0;
            pendLo  <= 32'd0;
            errReg  <= 1'b0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
            hiReg   <= hiNext;
            loReg   <= loNext;
            pendHi  <= pendHiNext;
            pendLo  <= pendLoNext;
            errReg  <= errNext;
        end
    end

    assign hi        = hiReg;
    assign lo        = loReg;
    assign busy      = (state == RUN);
    assign err_start = errReg;
    assign stall_md  = md_D & (busy | (start & isArith));

endmodule
